// File: rtl/branch_rs_pkg.sv
// -----------------------------------------------------------------------------
// branch_rs_pkg
// Shared definitions for the branch reservation station: address/word/tag
// types, the branch opcode encoding, the UNLOCKED tag and ZERO word constants,
// plus the CDB tag-match helper used by both allocation and wakeup paths.
// -----------------------------------------------------------------------------
package branch_rs_pkg;

   localparam int ADDR_W = 32;
   localparam int WORD_W = 32;
   localparam int TAG_W  = 5;

   typedef logic [ADDR_W-1:0] addr_t;
   typedef logic [WORD_W-1:0] word_t;
   typedef logic [TAG_W-1:0]  regtag_t;

   typedef enum logic [2:0] {
      BR_NOP  = 3'd0,
      BR_BEQ  = 3'd1,
      BR_BNE  = 3'd2,
      BR_BLT  = 3'd3,
      BR_BGE  = 3'd4,
      BR_BLTU = 3'd5,
      BR_BGEU = 3'd6,
      BR_JAL  = 3'd7
   } sinst_t;

   // Tag value meaning "operand value is present".
   localparam regtag_t UNLOCKED = '0;
   localparam word_t   ZERO     = '0;

   // A broadcast only wakes operands that are actually waiting.
   function automatic logic tag_hit(input regtag_t tag, input logic cdb_en,
                                    input regtag_t cdb_tag);
      return cdb_en && (tag != UNLOCKED) && (tag == cdb_tag);
   endfunction

endpackage

// File: rtl/branch_rs_select.sv
// -----------------------------------------------------------------------------
// branch_rs_select
// Combinational picker over the ready vector of the branch reservation station.
//   ready     : one bit per entry, entry may issue this cycle
//   age       : (BRANCH_RS_AGE_ORDER_EN only) packed per-entry age, larger = older
//   grant_vld : some entry was selected
//   grant_idx : index of the selected entry
// Default build picks the lowest-index ready entry; with BRANCH_RS_AGE_ORDER_EN
// defined it picks the oldest ready entry, ties going to the lower index.
// -----------------------------------------------------------------------------
module branch_rs_select #(
   parameter int DEPTH = 4
) (
   input  logic [DEPTH-1:0]                 ready,
`ifdef BRANCH_RS_AGE_ORDER_EN
   input  logic [DEPTH*$clog2(DEPTH)-1:0]   age,
`endif
   output logic                             grant_vld,
   output logic [$clog2(DEPTH)-1:0]         grant_idx
);

   localparam int IW = $clog2(DEPTH);

`ifdef BRANCH_RS_AGE_ORDER_EN
   logic [IW-1:0] best_age;

   always_comb begin
      grant_vld = 1'b0;
      grant_idx = '0;
      best_age  = '0;
      // Strictly-greater compare keeps the lower index on equal ages.
      for (int i = 0; i < DEPTH; i++) begin
         if (ready[i] && (!grant_vld || (age[i*IW +: IW] > best_age))) begin
            grant_vld = 1'b1;
            grant_idx = IW'(i);
            best_age  = age[i*IW +: IW];
         end
      end
   end
`else
   always_comb begin
      grant_vld = 1'b0;
      grant_idx = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (ready[i]) begin
            grant_vld = 1'b1;
            grant_idx = IW'(i);
         end
      end
   end
`endif

endmodule

// File: rtl/branch_rs.sv
// -----------------------------------------------------------------------------
// branch_rs
// Branch reservation station: holds DEPTH branches waiting on operands, wakes
// them from the common data bus and issues one ready branch per cycle.
//   clk, rst_n         : clock, synchronous active-low reset
//   rdy                : global enable, low freezes all state
//   alloc_*            : new branch (op, pc, offset, operand tags/values)
//   cdb_en/tag/data    : result broadcast
//   flush_in           : drop every entry and the issue packet
//   full_out           : no free entry (combinational from valid bits)
//   branch_*_out       : registered issue packet to the execute stage
// Optional: BRANCH_RS_AGE_ORDER_EN adds per-entry age counters and issues the
// oldest ready entry instead of the lowest-index one.
// -----------------------------------------------------------------------------
module branch_rs
   import branch_rs_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic    clk,
   input  logic    rst_n,
   input  logic    rdy,
   input  logic    alloc_en,
   input  sinst_t  alloc_op,
   input  addr_t   alloc_pc,
   input  word_t   alloc_offset,
   input  regtag_t alloc_tagx,
   input  regtag_t alloc_tagy,
   input  word_t   alloc_datax,
   input  word_t   alloc_datay,
   input  logic    cdb_en,
   input  regtag_t cdb_tag,
   input  word_t   cdb_data,
   input  logic    flush_in,
   output logic    full_out,
   output logic    branch_busy_out,
   output sinst_t  branch_op_out,
   output addr_t   branch_pc_out,
   output word_t   branch_offset_out,
   output regtag_t branch_tagx_out,
   output regtag_t branch_tagy_out,
   output word_t   branch_datax_out,
   output word_t   branch_datay_out
);

   localparam int IW = $clog2(DEPTH);

   logic [DEPTH-1:0] valid_q;
   sinst_t           op_q    [DEPTH];
   addr_t            pc_q    [DEPTH];
   word_t            off_q   [DEPTH];
   regtag_t          tagx_q  [DEPTH];
   regtag_t          tagy_q  [DEPTH];
   word_t            datax_q [DEPTH];
   word_t            datay_q [DEPTH];

   logic [DEPTH-1:0] ready;
   logic [IW-1:0]    free_idx;
   logic             iss_vld;
   logic [IW-1:0]    iss_idx;
   logic             do_alloc;
   logic             step;

   assign full_out = &valid_q;
   assign do_alloc = alloc_en && !full_out;
   // Normal (non-flush) update of the station this cycle.
   assign step     = rst_n && rdy && !flush_in;

   // Readiness comes from registered state only, so an entry allocated or
   // woken this cycle becomes issuable next cycle.
   always_comb begin
      ready    = '0;
      free_idx = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         ready[i] = valid_q[i] && (tagx_q[i] == UNLOCKED) && (tagy_q[i] == UNLOCKED);
         if (!valid_q[i]) free_idx = IW'(i);
      end
   end

`ifdef BRANCH_RS_AGE_ORDER_EN
   logic [DEPTH*IW-1:0] age_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         age_q <= '0;
      end else if (step && do_alloc) begin
         for (int i = 0; i < DEPTH; i++) begin
            if (free_idx == IW'(i))
               age_q[i*IW +: IW] <= '0;
            else if (valid_q[i] && (age_q[i*IW +: IW] != IW'(DEPTH - 1)))
               age_q[i*IW +: IW] <= age_q[i*IW +: IW] + IW'(1);
         end
      end
   end
`endif

   branch_rs_select #(.DEPTH(DEPTH)) u_select (
      .ready     (ready),
`ifdef BRANCH_RS_AGE_ORDER_EN
      .age       (age_q),
`endif
      .grant_vld (iss_vld),
      .grant_idx (iss_idx)
   );

   // Control and issue register stage
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         valid_q           <= '0;
         branch_busy_out   <= 1'b0;
         branch_op_out     <= BR_NOP;
         branch_pc_out     <= ZERO;
         branch_offset_out <= ZERO;
         branch_tagx_out   <= UNLOCKED;
         branch_tagy_out   <= UNLOCKED;
         branch_datax_out  <= ZERO;
         branch_datay_out  <= ZERO;
      end else if (rdy) begin
         branch_tagx_out <= UNLOCKED;
         branch_tagy_out <= UNLOCKED;
         if (!flush_in && iss_vld) begin
            valid_q[iss_idx]  <= 1'b0;
            branch_busy_out   <= 1'b1;
            branch_op_out     <= op_q[iss_idx];
            branch_pc_out     <= pc_q[iss_idx];
            branch_offset_out <= off_q[iss_idx];
            branch_datax_out  <= datax_q[iss_idx];
            branch_datay_out  <= datay_q[iss_idx];
         end else begin
            branch_busy_out   <= 1'b0;
            branch_op_out     <= BR_NOP;
            branch_pc_out     <= ZERO;
            branch_offset_out <= ZERO;
            branch_datax_out  <= ZERO;
            branch_datay_out  <= ZERO;
         end
         // The free slot is never the issuing one: issue needs a valid entry.
         if (flush_in)
            valid_q <= '0;
         else if (do_alloc)
            valid_q[free_idx] <= 1'b1;
      end
   end

   // Entry payload stage: allocation fill and CDB wakeup
   always_ff @(posedge clk) begin
      if (step) begin
         for (int i = 0; i < DEPTH; i++) begin
            if (do_alloc && (free_idx == IW'(i))) begin
               op_q[i]  <= alloc_op;
               pc_q[i]  <= alloc_pc;
               off_q[i] <= alloc_offset;
               if (tag_hit(alloc_tagx, cdb_en, cdb_tag)) begin
                  tagx_q[i]  <= UNLOCKED;
                  datax_q[i] <= cdb_data;
               end else begin
                  tagx_q[i]  <= alloc_tagx;
                  datax_q[i] <= alloc_datax;
               end
               if (tag_hit(alloc_tagy, cdb_en, cdb_tag)) begin
                  tagy_q[i]  <= UNLOCKED;
                  datay_q[i] <= cdb_data;
               end else begin
                  tagy_q[i]  <= alloc_tagy;
                  datay_q[i] <= alloc_datay;
               end
            end else if (valid_q[i]) begin
               if (tag_hit(tagx_q[i], cdb_en, cdb_tag)) begin
                  tagx_q[i]  <= UNLOCKED;
                  datax_q[i] <= cdb_data;
               end
               if (tag_hit(tagy_q[i], cdb_en, cdb_tag)) begin
                  tagy_q[i]  <= UNLOCKED;
                  datay_q[i] <= cdb_data;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_branch_rs.sv
module tb_branch_rs;
   import branch_rs_pkg::*;

   localparam int DEPTH = 4;
   typedef logic [141:0] pkt_t;

   logic    clk = 1'b0;
   logic    rst_n, rdy, alloc_en, cdb_en, flush_in;
   sinst_t  alloc_op;
   addr_t   alloc_pc;
   word_t   alloc_offset, alloc_datax, alloc_datay, cdb_data;
   regtag_t alloc_tagx, alloc_tagy, cdb_tag;
   logic    full_out, branch_busy_out;
   sinst_t  branch_op_out;
   addr_t   branch_pc_out;
   word_t   branch_offset_out, branch_datax_out, branch_datay_out;
   regtag_t branch_tagx_out, branch_tagy_out;

   pkt_t sb[$];
   pkt_t exp_p;
   int   compared = 0;
   int   mismatched = 0;

   localparam pkt_t IDLE_PKT = {1'b0, BR_NOP, ZERO, ZERO, UNLOCKED, UNLOCKED, ZERO, ZERO};

   branch_rs #(.DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n), .rdy(rdy), .alloc_en(alloc_en),
      .alloc_op(alloc_op), .alloc_pc(alloc_pc), .alloc_offset(alloc_offset),
      .alloc_tagx(alloc_tagx), .alloc_tagy(alloc_tagy),
      .alloc_datax(alloc_datax), .alloc_datay(alloc_datay),
      .cdb_en(cdb_en), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
      .flush_in(flush_in), .full_out(full_out),
      .branch_busy_out(branch_busy_out), .branch_op_out(branch_op_out),
      .branch_pc_out(branch_pc_out), .branch_offset_out(branch_offset_out),
      .branch_tagx_out(branch_tagx_out), .branch_tagy_out(branch_tagy_out),
      .branch_datax_out(branch_datax_out), .branch_datay_out(branch_datay_out)
   );

   always #5 clk = ~clk;

   function automatic pkt_t mk(input sinst_t op, input addr_t pc, input word_t off,
                               input word_t dx, input word_t dy);
      return {1'b1, op, pc, off, UNLOCKED, UNLOCKED, dx, dy};
   endfunction

   function automatic pkt_t got();
      return {branch_busy_out, branch_op_out, branch_pc_out, branch_offset_out,
              branch_tagx_out, branch_tagy_out, branch_datax_out, branch_datay_out};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pop_exp(output pkt_t e);
      if (sb.size() == 0) e = '1;
      else e = sb.pop_front();
   endtask

   task automatic clear_in();
      rst_n = 1'b1; rdy = 1'b1; alloc_en = 1'b0; flush_in = 1'b0; cdb_en = 1'b0;
      alloc_op = BR_NOP; alloc_pc = '0; alloc_offset = '0;
      alloc_tagx = UNLOCKED; alloc_tagy = UNLOCKED; alloc_datax = '0; alloc_datay = '0;
      cdb_tag = UNLOCKED; cdb_data = '0;
   endtask

   task automatic alloc_set(input sinst_t op, input addr_t pc, input word_t off,
                            input regtag_t tx, input word_t dx, input regtag_t ty, input word_t dy);
      alloc_en = 1'b1; alloc_op = op; alloc_pc = pc; alloc_offset = off;
      alloc_tagx = tx; alloc_datax = dx; alloc_tagy = ty; alloc_datay = dy;
   endtask

   task automatic cdb_set(input regtag_t t, input word_t d);
      cdb_en = 1'b1; cdb_tag = t; cdb_data = d;
   endtask

   task automatic test_reset();
      clear_in();
      rst_n = 1'b0; rdy = 1'b0; flush_in = 1'b1;
      alloc_set(BR_BEQ, 32'h44, 32'h4, UNLOCKED, 32'h1, UNLOCKED, 32'h2);
      tick(); tick();
      compared++;
      if (got() !== IDLE_PKT) begin
         mismatched++; $display("FAIL reset_outputs: got %h expected %h", got(), IDLE_PKT);
      end
      compared++;
      if (full_out !== 1'b0) begin
         mismatched++; $display("FAIL reset_full: got %b expected 0", full_out);
      end
      clear_in();
      tick(); tick();
      compared++;
      if (branch_busy_out !== 1'b0) begin
         mismatched++; $display("FAIL reset_no_alloc: busy got %b expected 0", branch_busy_out);
      end
   endtask

   task automatic test_basic();
      clear_in();
      alloc_set(BR_BEQ, 32'h100, 32'h20, UNLOCKED, 32'd5, UNLOCKED, 32'd5);
      sb.push_back(mk(BR_BEQ, 32'h100, 32'h20, 32'd5, 32'd5));
      tick();
      clear_in();
      compared++;
      if (branch_busy_out !== 1'b0) begin
         mismatched++; $display("FAIL basic_alloc_cycle: busy got %b expected 0", branch_busy_out);
      end
      tick();
      pop_exp(exp_p);
      compared++;
      if (got() !== exp_p) begin
         mismatched++; $display("FAIL basic_issue: got %h expected %h", got(), exp_p);
      end
      tick();
      compared++;
      if (got() !== IDLE_PKT) begin
         mismatched++; $display("FAIL basic_idle_after: got %h expected %h", got(), IDLE_PKT);
      end
   endtask

   task automatic test_wakeup();
      clear_in();
      alloc_set(BR_BNE, 32'h140, 32'h8, 5'd3, 32'hBAD, UNLOCKED, 32'h2);
      sb.push_back(mk(BR_BNE, 32'h140, 32'h8, 32'h7, 32'h2));
      tick();
      clear_in();
      cdb_set(5'd9, 32'h99);
      tick();
      clear_in();
      compared++;
      if (branch_busy_out !== 1'b0) begin
         mismatched++; $display("FAIL wakeup_wrong_tag: busy got %b expected 0", branch_busy_out);
      end
      tick();
      compared++;
      if (branch_busy_out !== 1'b0) begin
         mismatched++; $display("FAIL wakeup_waiting: busy got %b expected 0", branch_busy_out);
      end
      cdb_set(5'd3, 32'h7);
      tick();
      clear_in();
      compared++;
      if (branch_busy_out !== 1'b0) begin
         mismatched++; $display("FAIL wakeup_same_cycle: busy got %b expected 0", branch_busy_out);
      end
      tick();
      pop_exp(exp_p);
      compared++;
      if (got() !== exp_p) begin
         mismatched++; $display("FAIL wakeup_issue: got %h expected %h", got(), exp_p);
      end
   endtask

   task automatic test_alloc_capture();
      clear_in();
      alloc_set(BR_BLT, 32'h180, 32'h10, UNLOCKED, 32'h4, 5'd2, 32'hBAD);
      cdb_set(5'd2, 32'h9);
      sb.push_back(mk(BR_BLT, 32'h180, 32'h10, 32'h4, 32'h9));
      tick();
      clear_in();
      tick();
      pop_exp(exp_p);
      compared++;
      if (got() !== exp_p) begin
         mismatched++; $display("FAIL capture_issue: got %h expected %h", got(), exp_p);
      end
   endtask

   task automatic test_full();
      clear_in();
      for (int k = 0; k < DEPTH; k++) begin
         alloc_set(BR_BGE, 32'h200 + 32'(k * 4), 32'(k), 5'd1, 32'hAAAA, UNLOCKED, 32'h50 + 32'(k));
         sb.push_back(mk(BR_BGE, 32'h200 + 32'(k * 4), 32'(k), 32'h11, 32'h50 + 32'(k)));
         tick();
         compared++;
         if (full_out !== (k == DEPTH - 1)) begin
            mismatched++; $display("FAIL full_fill_%0d: got %b expected %b", k, full_out, (k == DEPTH - 1));
         end
      end
      alloc_set(BR_JAL, 32'hDEAD, 32'h0, UNLOCKED, 32'h1, UNLOCKED, 32'h1);
      tick();
      clear_in();
      compared++;
      if ({full_out, branch_busy_out} !== 2'b10) begin
         mismatched++; $display("FAIL full_ignore_alloc: full/busy got %b expected 10", {full_out, branch_busy_out});
      end
      cdb_set(5'd1, 32'h11);
      tick();
      clear_in();
      for (int k = 0; k < DEPTH; k++) begin
         tick();
         pop_exp(exp_p);
         compared++;
         if (got() !== exp_p) begin
            mismatched++; $display("FAIL full_drain_%0d: got %h expected %h", k, got(), exp_p);
         end
         compared++;
         if (full_out !== 1'b0) begin
            mismatched++; $display("FAIL full_clear_%0d: got %b expected 0", k, full_out);
         end
      end
      tick();
      compared++;
      if (branch_busy_out !== 1'b0) begin
         mismatched++; $display("FAIL full_no_extra: busy got %b expected 0", branch_busy_out);
      end
   endtask

   task automatic test_flush();
      clear_in();
      for (int k = 0; k < 3; k++) begin
         alloc_set(BR_BLTU, 32'h400 + 32'(k), 32'h0, 5'd2, 32'h0, UNLOCKED, 32'h0);
         tick();
      end
      flush_in = 1'b1;
      alloc_set(BR_BEQ, 32'h500, 32'h0, UNLOCKED, 32'h1, UNLOCKED, 32'h1);
      tick();
      clear_in();
      compared++;
      if ({full_out, got()} !== {1'b0, IDLE_PKT}) begin
         mismatched++; $display("FAIL flush_state: full=%b pkt=%h expected full=0 pkt=%h", full_out, got(), IDLE_PKT);
      end
      cdb_set(5'd2, 32'h22);
      for (int k = 0; k < 3; k++) begin
         tick();
         clear_in();
         compared++;
         if (branch_busy_out !== 1'b0) begin
            mismatched++; $display("FAIL flush_no_issue_%0d: busy got %b expected 0", k, branch_busy_out);
         end
      end
   endtask

   task automatic test_rdy_hold();
      clear_in();
      rdy = 1'b0;
      alloc_set(BR_BGEU, 32'h600, 32'h0, UNLOCKED, 32'h1, UNLOCKED, 32'h1);
      tick();
      clear_in();
      tick(); tick();
      compared++;
      if (branch_busy_out !== 1'b0) begin
         mismatched++; $display("FAIL rdy_alloc_ignored: busy got %b expected 0", branch_busy_out);
      end
      alloc_set(BR_BGEU, 32'h604, 32'h3, UNLOCKED, 32'h6, UNLOCKED, 32'h7);
      sb.push_back(mk(BR_BGEU, 32'h604, 32'h3, 32'h6, 32'h7));
      tick();
      clear_in();
      rdy = 1'b0;
      tick(); tick();
      compared++;
      if (branch_busy_out !== 1'b0) begin
         mismatched++; $display("FAIL rdy_frozen: busy got %b expected 0", branch_busy_out);
      end
      rdy = 1'b1;
      tick();
      pop_exp(exp_p);
      compared++;
      if (got() !== exp_p) begin
         mismatched++; $display("FAIL rdy_issue: got %h expected %h", got(), exp_p);
      end
      rdy = 1'b0;
      flush_in = 1'b1;
      tick();
      compared++;
      if (got() !== exp_p) begin
         mismatched++; $display("FAIL rdy_hold_outputs: got %h expected %h", got(), exp_p);
      end
      clear_in();
      tick();
      compared++;
      if (branch_busy_out !== 1'b0) begin
         mismatched++; $display("FAIL rdy_release: busy got %b expected 0", branch_busy_out);
      end
   endtask

   task automatic test_reset_mid();
      clear_in();
      alloc_set(BR_BEQ, 32'h700, 32'h0, 5'd4, 32'h0, UNLOCKED, 32'h0);
      tick();
      clear_in();
      rst_n = 1'b0;
      cdb_set(5'd4, 32'h44);
      alloc_set(BR_BNE, 32'h704, 32'h0, UNLOCKED, 32'h0, UNLOCKED, 32'h0);
      tick();
      clear_in();
      compared++;
      if ({full_out, got()} !== {1'b0, IDLE_PKT}) begin
         mismatched++; $display("FAIL rstmid_state: full=%b pkt=%h expected full=0 pkt=%h", full_out, got(), IDLE_PKT);
      end
      tick(); tick();
      compared++;
      if (branch_busy_out !== 1'b0) begin
         mismatched++; $display("FAIL rstmid_no_issue: busy got %b expected 0", branch_busy_out);
      end
   endtask

   task automatic test_age_order();
      clear_in();
      alloc_set(BR_BLT, 32'h300, 32'h1, 5'd5, 32'h0, UNLOCKED, 32'h1);
      sb.push_back(mk(BR_BLT, 32'h300, 32'h1, 32'h55, 32'h1));
      tick();
      alloc_set(BR_BGE, 32'h304, 32'h2, 5'd6, 32'h0, UNLOCKED, 32'h2);
      tick();
      alloc_set(BR_BEQ, 32'h308, 32'h3, 5'd1, 32'h0, UNLOCKED, 32'h3);
      tick();
      clear_in();
      cdb_set(5'd5, 32'h55);
      tick();
      clear_in();
      tick();
      pop_exp(exp_p);
      compared++;
      if (got() !== exp_p) begin
         mismatched++; $display("FAIL age_first_issue: got %h expected %h", got(), exp_p);
      end
      alloc_set(BR_BNE, 32'h30C, 32'h4, 5'd1, 32'h0, UNLOCKED, 32'h4);
      tick();
      clear_in();
      cdb_set(5'd1, 32'h33);
`ifdef BRANCH_RS_AGE_ORDER_EN
      sb.push_back(mk(BR_BEQ, 32'h308, 32'h3, 32'h33, 32'h3));
      sb.push_back(mk(BR_BNE, 32'h30C, 32'h4, 32'h33, 32'h4));
`else
      sb.push_back(mk(BR_BNE, 32'h30C, 32'h4, 32'h33, 32'h4));
      sb.push_back(mk(BR_BEQ, 32'h308, 32'h3, 32'h33, 32'h3));
`endif
      sb.push_back(mk(BR_BGE, 32'h304, 32'h2, 32'h66, 32'h2));
      tick();
      clear_in();
      for (int k = 0; k < 2; k++) begin
         tick();
         pop_exp(exp_p);
         compared++;
         if (got() !== exp_p) begin
            mismatched++; $display("FAIL age_order_%0d: got %h expected %h", k, got(), exp_p);
         end
      end
      cdb_set(5'd6, 32'h66);
      tick();
      clear_in();
      tick();
      pop_exp(exp_p);
      compared++;
      if (got() !== exp_p) begin
         mismatched++; $display("FAIL age_last_issue: got %h expected %h", got(), exp_p);
      end
      tick();
      compared++;
      if (branch_busy_out !== 1'b0) begin
         mismatched++; $display("FAIL age_drained: busy got %b expected 0", branch_busy_out);
      end
   endtask

   initial begin
      clear_in();
      test_reset();
      test_basic();
      test_wakeup();
      test_alloc_capture();
      test_full();
      test_flush();
      test_rdy_hold();
      test_reset_mid();
      test_age_order();
      compared++;
      if (sb.size() != 0) begin
         mismatched++; $display("FAIL scoreboard_empty: %0d left expected 0", sb.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/branch_rs.md
BRANCH_RS -- requirements
Module: branch_rs

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of reservation entries (power of two, 2..8).
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-004 SHALL have port rdy  input  1  global enable; low freezes all state and holds outputs.
REQ-005 SHALL have port alloc_en  input  1  allocate one branch this cycle.
REQ-006 SHALL have ports alloc_op `sinst_t, alloc_pc `addr_t, alloc_offset `word_t  input  branch op, its PC and immediate.
REQ-007 SHALL have ports alloc_tagx/alloc_tagy `regtag_t, alloc_datax/alloc_datay `word_t  input  operand tags (`UNLOCKED = value valid) and values.
REQ-008 SHALL have ports cdb_en 1, cdb_tag `regtag_t, cdb_data `word_t  input  result broadcast.
REQ-009 SHALL have port flush_in  input  1  discard all entries.
REQ-010 SHALL have port full_out  output  1  to allocator, no free entry.
REQ-011 SHALL have ports branch_busy_out 1, branch_op_out, branch_pc_out, branch_offset_out, branch_tagx_out, branch_tagy_out, branch_datax_out, branch_datay_out  output  issue packet to the execute stage.

Function
REQ-012 SHALL hold per entry: valid, op, pc, offset, tagx, datax, tagy, datay.
REQ-013 SHALL write alloc fields into the lowest-index free entry on alloc_en when not full_out; alloc_en while full SHALL be ignored.
REQ-014 SHALL, when cdb_en and an entry's valid tag equals cdb_tag, load cdb_data into that operand and set its tag to `UNLOCKED.
REQ-015 SHALL capture a CDB match against alloc_tagx/alloc_tagy in the allocation cycle, storing cdb_data with tag `UNLOCKED.
REQ-016 SHALL treat an entry as ready when valid with both tags `UNLOCKED; wakeup in cycle N makes it issuable in cycle N+1.
REQ-017 SHALL select at most one ready entry per cycle, register it onto the issue outputs at the next edge with branch_busy_out=1 and both tags `UNLOCKED, and free that entry at the same edge.
REQ-018 SHALL drive branch_busy_out=0, tags `UNLOCKED, other issue fields `ZERO in cycles without issue.
REQ-019 SHALL compute full_out combinationally as all entries valid; a same-cycle issue SHALL NOT clear full_out until the following cycle.
REQ-020 SHALL allow allocate, wakeup and issue of different entries in one cycle; an allocating entry SHALL NOT issue in its allocation cycle.
REQ-021 SHALL, on flush_in, clear all valid bits and the issue outputs at the next edge; flush SHALL take priority over simultaneous alloc_en.
REQ-022 SHALL, with rdy low, ignore alloc_en, cdb_en and flush_in and hold all registers.

Reset
REQ-023 SHALL, on rst_n low at a clock edge, clear all valid bits, set branch_busy_out=0, issue tags `UNLOCKED, remaining outputs `ZERO; full_out=0 from the next cycle.
REQ-024 SHALL let reset override rdy, flush and allocation, including mid-wakeup.

Configuration
REQ-025 SHALL, with BRANCH_RS_AGE_ORDER_EN defined, keep a per-entry age counter (reset on allocate, incremented on each other allocation, saturating at DEPTH-1) and issue the oldest ready entry.
REQ-026 SHALL, without BRANCH_RS_AGE_ORDER_EN, issue the lowest-index ready entry and contain no age state.

Structure
REQ-027 SHALL take `addr_t, `word_t, `regtag_t, `sinst_t, `UNLOCKED, `ZERO and branch opcode constants from the shared defines package; no local redefinition.
REQ-028 SHALL use one sub-module, branch_rs_select, a combinational ready-vector priority picker (lowest-index or age-based).

Verification
REQ-029 SHALL cover: alloc BEQ pc=0x100 offset=0x20 both tags `UNLOCKED datax=datay=5 -> next cycle branch_busy_out=1, pc_out=0x100, datax_out=5.
REQ-030 SHALL cover: alloc tagx=3, idle 2 cycles, then cdb_en tag=3 data=0x7 -> issue exactly one cycle after broadcast with datax_out=0x7.
REQ-031 SHALL cover: alloc tagy=2 with cdb_en tag=2 data=0x9 in same cycle -> issue next cycle with datay_out=0x9.
REQ-032 SHALL cover: allocate DEPTH=4 entries all waiting on tag 1 -> full_out=1, fifth alloc_en ignored; cdb tag 1 -> one issue per cycle over 4 cycles, full_out=0 after first issue cycle.
REQ-033 SHALL cover: 3 waiting entries plus flush_in with alloc_en -> next cycle no valid entries, full_out=0, no issue.
REQ-034 SHALL cover: with BRANCH_RS_AGE_ORDER_EN, alloc A into entry 2 then B into entry 0, both woken together -> A issues first; without macro -> B first.
